dram_wrq_ctl: RTL and testbench

Controller for the DRAM write data queue: four 16x65 register-file banks, one per 64-bit quarter of a 256-bit line. It accepts 256-bit write lines from the CPU side as four 64-bit beats and allocates a free queue entry per line. It sequences the per-bank write chip-selects and tracks completed lines in arrival order. It grants DRAM-side read requests by driving the queue read address/enable, freeing each entry as it is read.

---
 rtl/dram_wrq_ctl.sv | 126 ++++++++++++
 tb/tb_dram_wrq_ctl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram_wrq_ctl.sv
// Write-queue controller for the four-bank DRAM write data queue: allocates an entry per
// 256-bit line, drives per-bank write strobes and hands completed lines to the DRAM side in order.
module dram_wrq_ctl (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        wr_vld,
  input  logic [63:0] wr_data,
  output logic        wr_rdy,
  output logic [3:0]  dram_cpu_wr_addr,
  output logic [63:0] dram_cpu_wr_data,
  output logic [3:0]  dram_cpu_wr_en,
  input  logic        rd_req,
  output logic        rd_gnt,
  output logic [4:0]  que_mem_addr,
  output logic        rd_data_vld,
  output logic [4:0]  wq_cnt,
  output logic        wq_empty,
  output logic        wq_full
);

  logic [15:0] free_reg, free_next;
  logic [1:0]  bcnt_reg;
  logic [3:0]  cur_ent_reg;
  logic [3:0]  alloc_ent;
  logic        wr_acc, alloc_fire, push, pop, rel_vld;

  logic [3:0]  cfifo_mem [16];
  logic [3:0]  wr_ptr_reg, rd_ptr_reg;
  logic [4:0]  cnt_reg;

  logic [3:0]  wr_addr_reg, wr_en_reg;
  logic [63:0] wr_data_reg;
  logic [4:0]  que_addr_reg;
  logic        rd_vld_reg;

  // Lowest-index free entry wins.
  always_comb begin
    alloc_ent = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (free_reg[i]) alloc_ent = 4'(i);
    end
  end

  assign wr_rdy     = (bcnt_reg != 2'd0) | (free_reg != 16'd0);
  assign wr_acc     = wr_vld & wr_rdy;
  assign alloc_fire = wr_acc & (bcnt_reg == 2'd0);
  assign push       = wr_acc & (bcnt_reg == 2'd3);
  assign wq_empty   = (cnt_reg == 5'd0);
  assign rd_gnt     = rd_req & ~wq_empty;
  assign pop        = rd_gnt;
  // The entry being read this cycle is released at the end of the cycle.
  assign rel_vld    = ~que_addr_reg[4];

  always_comb begin
    free_next = free_reg;
    if (rel_vld)    free_next[que_addr_reg[3:0]] = 1'b1;
    if (alloc_fire) free_next[alloc_ent] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      free_reg    <= 16'hFFFF;
      bcnt_reg    <= 2'd0;
      cur_ent_reg <= 4'd0;
    end else begin
      free_reg <= free_next;
      if (wr_acc)     bcnt_reg    <= bcnt_reg + 2'd1;
      if (alloc_fire) cur_ent_reg <= alloc_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_en_reg   <= 4'hF;
      wr_addr_reg <= 4'd0;
      wr_data_reg <= 64'd0;
    end else if (wr_acc) begin
      wr_en_reg   <= ~(4'b0001 << bcnt_reg);
      wr_addr_reg <= (bcnt_reg == 2'd0) ? alloc_ent : cur_ent_reg;
      wr_data_reg <= wr_data;
    end else begin
      wr_en_reg   <= 4'hF;
    end
  end

  // Completion FIFO storage; contents need no reset since the count guards every read.
  always_ff @(posedge clk) begin
    if (push) cfifo_mem[wr_ptr_reg] <= cur_ent_reg;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_reg <= 4'd0;
      rd_ptr_reg <= 4'd0;
      cnt_reg    <= 5'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 4'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 4'd1;
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 5'd1;
        2'b01:   cnt_reg <= cnt_reg - 5'd1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      que_addr_reg <= 5'h10;
      rd_vld_reg   <= 1'b0;
    end else begin
      if (rd_gnt) que_addr_reg <= {1'b0, cfifo_mem[rd_ptr_reg]};
      else        que_addr_reg <= {1'b1, que_addr_reg[3:0]};
      rd_vld_reg <= ~que_addr_reg[4];
    end
  end

  assign dram_cpu_wr_en   = wr_en_reg;
  assign dram_cpu_wr_addr = wr_addr_reg;
  assign dram_cpu_wr_data = wr_data_reg;
  assign que_mem_addr     = que_addr_reg;
  assign rd_data_vld      = rd_vld_reg;
  assign wq_cnt           = cnt_reg;
  assign wq_full          = (free_reg == 16'd0) & (bcnt_reg == 2'd0);

endmodule

// File: tb/tb_dram_wrq_ctl.sv
// Directed bench for dram_wrq_ctl: line writes, fill/drain, out-of-order frees,
// concurrent push/pop, asynchronous reset mid-line and reads while empty.
module tb_dram_wrq_ctl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        wr_vld;
  logic [63:0] wr_data;
  logic        wr_rdy;
  logic [3:0]  dram_cpu_wr_addr;
  logic [63:0] dram_cpu_wr_data;
  logic [3:0]  dram_cpu_wr_en;
  logic        rd_req;
  logic        rd_gnt;
  logic [4:0]  que_mem_addr;
  logic        rd_data_vld;
  logic [4:0]  wq_cnt;
  logic        wq_empty;
  logic        wq_full;

  int check_cnt = 0;
  int error_cnt = 0;

  always #5 clk = ~clk;

  dram_wrq_ctl dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .wr_vld           (wr_vld),
    .wr_data          (wr_data),
    .wr_rdy           (wr_rdy),
    .dram_cpu_wr_addr (dram_cpu_wr_addr),
    .dram_cpu_wr_data (dram_cpu_wr_data),
    .dram_cpu_wr_en   (dram_cpu_wr_en),
    .rd_req           (rd_req),
    .rd_gnt           (rd_gnt),
    .que_mem_addr     (que_mem_addr),
    .rd_data_vld      (rd_data_vld),
    .wq_cnt           (wq_cnt),
    .wq_empty         (wq_empty),
    .wq_full          (wq_full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four beats of one line; each beat must be accepted and land on exp_ent.
  task automatic send_line(input logic [3:0] exp_ent, input logic [63:0] base);
    for (int b = 0; b < 4; b++) begin
      wr_vld  = 1'b1;
      wr_data = base + 64'(b);
      #1;
      chk("wr_rdy_beat", {63'd0, wr_rdy}, 64'd1);
      tick();
      chk("wr_en", {60'd0, dram_cpu_wr_en}, {60'd0, ~(4'b0001 << b)});
      chk("wr_addr", {60'd0, dram_cpu_wr_addr}, {60'd0, exp_ent});
      chk("wr_data", dram_cpu_wr_data, base + 64'(b));
    end
    wr_vld = 1'b0;
  endtask

  // Grant, read address one cycle later, data valid the cycle after.
  task automatic do_read(input logic [3:0] exp_ent);
    rd_req = 1'b1;
    #1;
    chk("rd_gnt", {63'd0, rd_gnt}, 64'd1);
    tick();
    rd_req = 1'b0;
    chk("que_mem_addr", {59'd0, que_mem_addr}, {59'd0, 1'b0, exp_ent});
    tick();
    chk("rd_data_vld", {63'd0, rd_data_vld}, 64'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_wr_rdy", {63'd0, wr_rdy}, 64'd1);
    chk("rst_wr_en", {60'd0, dram_cpu_wr_en}, 64'hF);
    chk("rst_wr_addr", {60'd0, dram_cpu_wr_addr}, 64'd0);
    chk("rst_wr_data", dram_cpu_wr_data, 64'd0);
    chk("rst_que_addr", {59'd0, que_mem_addr}, 64'h10);
    chk("rst_rd_gnt", {63'd0, rd_gnt}, 64'd0);
    chk("rst_rd_vld", {63'd0, rd_data_vld}, 64'd0);
    chk("rst_wq_cnt", {59'd0, wq_cnt}, 64'd0);
    chk("rst_wq_empty", {63'd0, wq_empty}, 64'd1);
    chk("rst_wq_full", {63'd0, wq_full}, 64'd0);
  endtask

  initial begin
    rst_l   = 1'b0;
    wr_vld  = 1'b0;
    wr_data = 64'd0;
    rd_req  = 1'b0;
    #12;
    chk_reset_outputs();
    rst_l = 1'b1;
    tick();

    // Single line after reset
    send_line(4'd0, 64'hA0);
    chk("single_cnt", {59'd0, wq_cnt}, 64'd1);
    tick();
    chk("single_en_idle", {60'd0, dram_cpu_wr_en}, 64'hF);
    do_read(4'd0);
    chk("single_cnt_after", {59'd0, wq_cnt}, 64'd0);
    chk("single_que_idle", {63'd0, que_mem_addr[4]}, 64'd1);

    // Fill all 16 entries
    for (int l = 0; l < 16; l++) send_line(4'(l), 64'h1000 + 64'(l * 16));
    chk("full_flag", {63'd0, wq_full}, 64'd1);
    chk("full_rdy", {63'd0, wr_rdy}, 64'd0);
    chk("full_cnt", {59'd0, wq_cnt}, 64'd16);
    wr_vld  = 1'b1;
    wr_data = 64'hDEAD;
    tick();
    tick();
    chk("stall_en", {60'd0, dram_cpu_wr_en}, 64'hF);
    chk("stall_rdy", {63'd0, wr_rdy}, 64'd0);
    wr_vld = 1'b0;
    rd_req = 1'b1;
    #1;
    chk("full_gnt", {63'd0, rd_gnt}, 64'd1);
    tick();
    rd_req = 1'b0;
    chk("full_que_addr", {59'd0, que_mem_addr}, 64'h00);
    chk("rdy_t1", {63'd0, wr_rdy}, 64'd0);
    tick();
    chk("rdy_t2", {63'd0, wr_rdy}, 64'd1);
    send_line(4'd0, 64'h2000);
    chk("refill_cnt", {59'd0, wq_cnt}, 64'd16);
    for (int l = 1; l < 16; l++) do_read(4'(l));
    do_read(4'd0);
    chk("drain_empty", {63'd0, wq_empty}, 64'd1);

    // Out-of-order frees
    send_line(4'd0, 64'h3000);
    send_line(4'd1, 64'h3010);
    send_line(4'd2, 64'h3020);
    do_read(4'd0);
    do_read(4'd1);
    send_line(4'd0, 64'h3030);
    send_line(4'd1, 64'h3040);
    send_line(4'd3, 64'h3050);
    do_read(4'd2);
    do_read(4'd0);
    do_read(4'd1);
    do_read(4'd3);
    chk("ooo_empty", {63'd0, wq_empty}, 64'd1);

    // Push and pop in the same cycle
    send_line(4'd0, 64'h4000);
    for (int b = 0; b < 3; b++) begin
      wr_vld  = 1'b1;
      wr_data = 64'h4010 + 64'(b);
      tick();
    end
    chk("pp_addr_b2", {60'd0, dram_cpu_wr_addr}, 64'd1);
    wr_data = 64'h4013;
    rd_req  = 1'b1;
    #1;
    chk("pp_gnt", {63'd0, rd_gnt}, 64'd1);
    tick();
    wr_vld = 1'b0;
    rd_req = 1'b0;
    chk("pp_cnt", {59'd0, wq_cnt}, 64'd1);
    chk("pp_que_addr", {59'd0, que_mem_addr}, 64'h00);
    tick();
    do_read(4'd1);

    // Twenty more lines wrap both FIFO pointers
    for (int l = 0; l < 20; l++) begin
      send_line(4'd0, 64'h5000 + 64'(l * 16));
      do_read(4'd0);
    end
    chk("wrap_empty", {63'd0, wq_empty}, 64'd1);

    // Asynchronous reset mid-line
    send_line(4'd0, 64'h6000);
    wr_vld  = 1'b1;
    wr_data = 64'h6100;
    tick();
    wr_data = 64'h6101;
    tick();
    wr_vld = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    chk_reset_outputs();
    #3;
    rst_l = 1'b1;
    tick();
    chk("post_rst_cnt", {59'd0, wq_cnt}, 64'd0);
    send_line(4'd0, 64'h7000);
    chk("post_rst_line_cnt", {59'd0, wq_cnt}, 64'd1);
    do_read(4'd0);

    // Read request while empty
    rd_req = 1'b1;
    #1;
    chk("empty_gnt", {63'd0, rd_gnt}, 64'd0);
    tick();
    chk("empty_que_en", {63'd0, que_mem_addr[4]}, 64'd1);
    chk("empty_cnt", {59'd0, wq_cnt}, 64'd0);
    tick();
    chk("empty_vld", {63'd0, rd_data_vld}, 64'd0);
    rd_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
